// File: rtl/apb_fifo_pkg.sv
// ----------------------------------------------------------------------------
// apb_fifo_pkg
// Shared definitions for the APB transmit-FIFO completer: register offsets,
// STATUS/CTRL bit positions and the completer FSM state type.
// ----------------------------------------------------------------------------
package apb_fifo_pkg;

    // Register offsets (byte addresses, compared against the full PADDR)
    localparam int unsigned DATA_OFS   = 32'h00;
    localparam int unsigned STATUS_OFS = 32'h04;
    localparam int unsigned CTRL_OFS   = 32'h08;

    // STATUS layout
    localparam int unsigned ST_EMPTY_BIT = 0;
    localparam int unsigned ST_FULL_BIT  = 1;
    localparam int unsigned ST_OVF_BIT   = 2;
    localparam int unsigned ST_COUNT_LSB = 8;
    localparam int unsigned ST_COUNT_W   = 8;

    // CTRL layout (self-clearing actions, nothing is stored)
    localparam int unsigned CTRL_FLUSH_BIT   = 0;
    localparam int unsigned CTRL_CLR_OVF_BIT = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// ----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with push, pop and flush. Flush has priority over every
// other operation. Pushes while full and pops while empty are ignored.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   push_i, data_i    write request and write word
//   pop_i             remove the head word
//   flush_i           discard all entries
//   count_o           registered occupancy (0..DEPTH)
//   full_o, empty_o   occupancy flags derived from count_o
//   head_o            word at the read pointer
// ----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         push_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    input  logic [DATA_WIDTH-1:0]        data_i,
    output logic [$clog2(DEPTH+1)-1:0]   count_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [DATA_WIDTH-1:0]        head_o
);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam int PTR_W = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  push_ok, pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // NOTE: storage has no reset; an empty count makes stale contents unreachable.
    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    // NOTE: every variable gets its hold value first so no path infers a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so natural overflow is the modulo wrap
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // NOTE: non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/apb_tx_fifo_slave.sv
// ----------------------------------------------------------------------------
// apb_tx_fifo_slave
// APB completer in front of a transmit FIFO. Writes to DATA push words; a
// valid/ready stream drains them. A DATA write while full stalls the bus
// until a slot frees, or ends with PSLVERR after WAIT_MAX stall cycles.
// Ports:
//   PCLK, PRESET                 clock, asynchronous active-high reset
//   PSEL, PENABLE, PWRITE        APB control
//   PADDR, PWDATA                APB address / write data
//   PRDATA, PREADY, PSLVERR      registered APB response
//   m_valid, m_ready, m_data     output stream (head of FIFO)
// ----------------------------------------------------------------------------
module apb_tx_fifo_slave
    import apb_fifo_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8,
    parameter int WAIT_MAX   = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESET,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    input  logic                  PWRITE,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data
);
    localparam int CNT_W  = $clog2(DEPTH+1);
    localparam int WAIT_W = $clog2(WAIT_MAX+1);

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  ovf_q, ovf_d;
    logic                  pready_q, pready_d;
    logic                  pslverr_q, pslverr_d;
    logic [DATA_WIDTH-1:0] prdata_q, prdata_d;

    logic                  fifo_push, fifo_pop, fifo_flush;
    logic                  fifo_full, fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic [DATA_WIDTH-1:0] status;
    logic                  sel_data, sel_status, sel_ctrl;

    sync_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk_i   (PCLK),
        .rst_i   (PRESET),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .data_i  (PWDATA),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .head_o  (m_data)
    );

    assign m_valid  = !fifo_empty;
    assign fifo_pop = m_valid && m_ready;

    assign sel_data   = (PADDR == ADDR_WIDTH'(DATA_OFS));
    assign sel_status = (PADDR == ADDR_WIDTH'(STATUS_OFS));
    assign sel_ctrl   = (PADDR == ADDR_WIDTH'(CTRL_OFS));

    always_comb begin
        status = '0;
        status[ST_EMPTY_BIT] = fifo_empty;
        status[ST_FULL_BIT]  = fifo_full;
        status[ST_OVF_BIT]   = ovf_q;
        status[ST_COUNT_LSB +: ST_COUNT_W] = ST_COUNT_W'(fifo_count);
    end

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        ovf_d      = ovf_q;
        pready_d   = pready_q;
        pslverr_d  = pslverr_q;
        prdata_d   = prdata_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;

        case (state_q)
            IDLE: begin
                if (PSEL && PENABLE) begin
                    if (PWRITE && sel_data && fifo_full) begin
                        state_d = STALL;
                        wait_d  = WAIT_W'(1);
                    end else begin
                        pready_d = 1'b1;
                        state_d  = RESP;
                        if (sel_data) begin
                            if (PWRITE) fifo_push = 1'b1;
                            else        prdata_d  = '0;
                        end else if (sel_status) begin
                            if (!PWRITE) prdata_d = status;
                        end else if (sel_ctrl) begin
                            if (PWRITE) begin
                                fifo_flush = PWDATA[CTRL_FLUSH_BIT];
                                if (PWDATA[CTRL_CLR_OVF_BIT]) ovf_d = 1'b0;
                            end else begin
                                prdata_d = '0;
                            end
                        end else begin
                            pslverr_d = 1'b1;
                        end
                    end
                end
            end

            STALL: begin
                if (!PSEL) begin
                    state_d = IDLE;
                end else if (!fifo_full) begin
                    // Full is registered: a pop seen last edge frees the slot now
                    fifo_push = 1'b1;
                    pready_d  = 1'b1;
                    state_d   = RESP;
                end else if (wait_q == WAIT_W'(WAIT_MAX)) begin
                    ovf_d     = 1'b1;
                    pready_d  = 1'b1;
                    pslverr_d = 1'b1;
                    state_d   = RESP;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end

            RESP: begin
                // PSEL/PENABLE are still high here; returning to IDLE without
                // decoding keeps the completing transfer from retriggering
                pready_d  = 1'b0;
                pslverr_d = 1'b0;
                state_d   = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            ovf_q     <= 1'b0;
            pready_q  <= 1'b0;
            pslverr_q <= 1'b0;
            prdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ovf_q     <= ovf_d;
            pready_q  <= pready_d;
            pslverr_q <= pslverr_d;
            prdata_q  <= prdata_d;
        end
    end

    assign PREADY  = pready_q;
    assign PSLVERR = pslverr_q;
    assign PRDATA  = prdata_q;

endmodule
